// File: rtl/pq_sched_pkg.sv
// Shared types and helpers for the PDES pending-event queue scheduler.
// Also holds the rotating-priority pick used by other shared PDES resources.
package pq_sched_pkg;

   localparam int NREQ_DEF   = 4;
   localparam int DWIDTH_DEF = 16;
   localparam int HDEPTH_DEF = 5;
   localparam int CAP        = 2**HDEPTH_DEF - 1;
   localparam int IDW        = $clog2(NREQ_DEF);
   localparam int MAXREQ     = 16;

   typedef enum logic [1:0] {RST_WAIT, RUN, DRAIN} state_t;

   typedef struct packed {
      logic       found;
      logic [3:0] idx;
   } pick_t;

   // First eligible index at or after rr_ptr, wrapping modulo n.
   // The loop runs downward so the closest candidate is assigned last and wins.
   function automatic pick_t rr_pick(input logic [MAXREQ-1:0] eligible,
                                     input logic [3:0] rr_ptr,
                                     input int n);
      pick_t      p;
      int         cand;
      logic [3:0] cidx;
      p = '0;
      for (int k = MAXREQ - 1; k >= 0; k--) begin
         if (k < n) begin
            cand = (int'(rr_ptr) + k) % n;
            cidx = 4'(cand);
            if (eligible[cidx]) begin
               p.found = 1'b1;
               p.idx   = cidx;
            end
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-wide rotating-priority picker. The pointer moves past the winner on each grant
// and holds when nothing is eligible.
module rr_arbiter
   import pq_sched_pkg::*;
#(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         eligible,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] winner,
   output logic                 found
);

   localparam int W = $clog2(N);
   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [W-1:0] rr_ptr;
   pick_t        pick;

   always_comb begin
      pick   = rr_pick(16'(eligible), 4'(rr_ptr), N);
      found  = pick.found;
      winner = pick.idx[W-1:0];
      gnt    = '0;
      if (pick.found) gnt[winner] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (found) begin
         rr_ptr <= (winner == LAST) ? '0 : winner + 1'b1;
      end
   end

endmodule

// File: rtl/pq_sched_arbiter.sv
// Shares one prio_q min-heap among NREQ simulation cores: round-robin enq/deq arbitration,
// prio_q reset sequencing and flush draining.
module pq_sched_arbiter
   import pq_sched_pkg::*;
#(
   parameter int NREQ       = NREQ_DEF,
   parameter int DWIDTH     = DWIDTH_DEF,
   parameter int HDEPTH     = HDEPTH_DEF,
   parameter int RST_CYCLES = 2
) (
   input  logic                    CLK,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_enq,
   input  logic [NREQ-1:0]         req_deq,
   input  logic [NREQ*DWIDTH-1:0]  req_data,
   output logic [NREQ-1:0]         gnt,
   output logic                    rsp_valid,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [DWIDTH-1:0]       rsp_data,
   input  logic                    flush,
   output logic                    flush_done,
   output logic                    ready,
   output logic                    pq_rst_n,
   output logic                    pq_enq,
   output logic                    pq_deq,
   output logic [DWIDTH-1:0]       pq_inp_data,
   input  logic [DWIDTH-1:0]       pq_out_data,
   input  logic [HDEPTH-1:0]       pq_count
);

   localparam int IW = $clog2(NREQ);
   localparam logic [HDEPTH-1:0] FULL_CNT = '1;
   localparam logic [7:0]        RST_LAST = 8'(RST_CYCLES - 1);

   state_t          state;
   logic [7:0]      rst_cnt;
   logic            full;
   logic            empty;
   logic [NREQ-1:0] eligible;
   logic [NREQ-1:0] arb_gnt;
   logic [IW-1:0]   winner;
   logic            found;
   logic            win_enq;

   // Flush and rst take the cycle away from requesters, so nothing is eligible then.
   always_comb begin
      full     = (pq_count == FULL_CNT);
      empty    = (pq_count == '0);
      eligible = '0;
      if (state == RUN && !flush && !rst) begin
         eligible = (req_enq & {NREQ{!full}}) | (req_deq & {NREQ{!empty}});
      end
   end

   rr_arbiter #(.N(NREQ)) u_arb (
      .clk      (CLK),
      .rst      (rst),
      .eligible (eligible),
      .gnt      (arb_gnt),
      .winner   (winner),
      .found    (found)
   );

   // A requester holding both requests gets its enqueue first unless the queue is full.
   always_comb begin
      win_enq     = req_enq[winner] && !full;
      gnt         = arb_gnt;
      pq_enq      = found && win_enq;
      pq_deq      = (found && !win_enq) || (state == DRAIN && !empty && !rst);
      pq_inp_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (IW'(i) == winner) pq_inp_data = req_data[i*DWIDTH +: DWIDTH];
      end
      pq_rst_n    = !rst && (state != RST_WAIT);
      ready       = !rst && (state == RUN);
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state      <= RST_WAIT;
         rst_cnt    <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_data   <= '0;
         flush_done <= 1'b0;
      end else begin
         rsp_valid  <= 1'b0;
         flush_done <= 1'b0;
         case (state)
            RST_WAIT: begin
               if (rst_cnt == RST_LAST) state <= RUN;
               else rst_cnt <= rst_cnt + 8'd1;
            end
            RUN: begin
               if (flush) begin
                  state <= DRAIN;
               end else if (pq_deq) begin
                  rsp_valid <= 1'b1;
                  rsp_id    <= winner;
                  rsp_data  <= pq_out_data;
               end
            end
            DRAIN: begin
               if (empty) begin
                  state      <= RUN;
                  flush_done <= 1'b1;
               end
            end
            default: state <= RST_WAIT;
         endcase
      end
   end

endmodule

// File: tb/tb_pq_sched_arbiter.sv
// Bench for pq_sched_arbiter: behavioural prio_q plus a response scoreboard
// filled when dequeue grants are driven.
module tb_pq_sched_arbiter;
   import pq_sched_pkg::*;

   logic        CLK;
   logic        rst;
   logic [3:0]  req_enq;
   logic [3:0]  req_deq;
   logic [63:0] req_data;
   logic [3:0]  gnt;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [15:0] rsp_data;
   logic        flush;
   logic        flush_done;
   logic        ready;
   logic        pq_rst_n;
   logic        pq_enq;
   logic        pq_deq;
   logic [15:0] pq_inp_data;
   logic [15:0] pq_out_data = '0;
   logic [4:0]  pq_count    = '0;

   int checks   = 0;
   int failures = 0;

   int unsigned mq[$];
   int          pos;
   int          exp_id[$];
   int          exp_data[$];

   pq_sched_arbiter #(.NREQ(4), .DWIDTH(16), .HDEPTH(5), .RST_CYCLES(2)) dut (
      .CLK         (CLK),
      .rst         (rst),
      .req_enq     (req_enq),
      .req_deq     (req_deq),
      .req_data    (req_data),
      .gnt         (gnt),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_data    (rsp_data),
      .flush       (flush),
      .flush_done  (flush_done),
      .ready       (ready),
      .pq_rst_n    (pq_rst_n),
      .pq_enq      (pq_enq),
      .pq_deq      (pq_deq),
      .pq_inp_data (pq_inp_data),
      .pq_out_data (pq_out_data),
      .pq_count    (pq_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Behavioural prio_q: sorted list, head is the minimum.
   always @(posedge CLK) begin
      if (!pq_rst_n) begin
         mq.delete();
      end else begin
         if (pq_deq && mq.size() > 0) void'(mq.pop_front());
         if (pq_enq && mq.size() < CAP) begin
            pos = mq.size();
            for (int k = mq.size() - 1; k >= 0; k--) if (int'(pq_inp_data) < mq[k]) pos = k;
            mq.insert(pos, int'(pq_inp_data));
         end
      end
      pq_count    <= 5'(mq.size());
      pq_out_data <= (mq.size() > 0) ? 16'(mq[0]) : 16'd0;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
      end
   endtask

   always @(negedge CLK) begin
      if (rsp_valid === 1'b1) begin
         if (exp_id.size() == 0) begin
            checkOutput("rsp_unexpected", 32'd1, 32'd0);
         end else begin
            checkOutput("rsp_id", 32'(rsp_id), 32'(exp_id.pop_front()));
            checkOutput("rsp_data", 32'(rsp_data), 32'(exp_data.pop_front()));
         end
      end
   end

   function automatic logic [63:0] mkData(input int id, input int val);
      return 64'(16'(val)) << (id * 16);
   endfunction

   task automatic applyStimulus(input logic [3:0] enq, input logic [3:0] deq,
                                input logic [63:0] data, input logic fl);
      @(negedge CLK);
      req_enq  = enq;
      req_deq  = deq;
      req_data = data;
      flush    = fl;
      #1;
   endtask

   task automatic idle();
      applyStimulus(4'b0, 4'b0, 64'b0, 1'b0);
   endtask

   task automatic enqOne(input int id, input int val);
      applyStimulus(4'(1 << id), 4'b0, mkData(id, val), 1'b0);
      checkOutput("enq_gnt", 32'(gnt), 32'(1 << id));
      checkOutput("enq_data", 32'(pq_inp_data), 32'(val));
   endtask

   task automatic deqOne(input int id, input int expVal);
      applyStimulus(4'b0, 4'(1 << id), 64'b0, 1'b0);
      checkOutput("deq_gnt", 32'(gnt), 32'(1 << id));
      checkOutput("deq_pq", 32'(pq_deq), 32'd1);
      exp_id.push_back(id);
      exp_data.push_back(expVal);
   endtask

   task automatic doFlush(input int expDeq, input int holdVal);
      int deqs;
      bit done;
      deqs = 0;
      done = 0;
      applyStimulus(4'b0001, 4'b0, mkData(0, holdVal), 1'b1);
      checkOutput("flush_gnt", 32'(gnt), 32'd0);
      for (int c = 0; c < 100 && !done; c++) begin
         applyStimulus(4'b0001, 4'b0, mkData(0, holdVal), 1'b0);
         if (flush_done === 1'b1) begin
            done = 1;
            checkOutput("flush_deqs", 32'(deqs), 32'(expDeq));
            checkOutput("flush_cnt", 32'(pq_count), 32'd0);
            checkOutput("flush_gnt_after", 32'(gnt), 32'd1);
         end else begin
            if (pq_deq === 1'b1) deqs++;
            checkOutput("drain_gnt", 32'(gnt), 32'd0);
            checkOutput("drain_ready", 32'(ready), 32'd0);
         end
      end
      if (!done) checkOutput("flush_timeout", 32'd0, 32'd1);
      idle();
      checkOutput("flush_done_pulse", 32'(flush_done), 32'd0);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_gnt"}, 32'(gnt), 32'd0);
      checkOutput({tag, "_enq"}, 32'(pq_enq), 32'd0);
      checkOutput({tag, "_deq"}, 32'(pq_deq), 32'd0);
      checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      checkOutput({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
      checkOutput({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
      checkOutput({tag, "_flush_done"}, 32'(flush_done), 32'd0);
      checkOutput({tag, "_ready"}, 32'(ready), 32'd0);
      checkOutput({tag, "_pq_rst_n"}, 32'(pq_rst_n), 32'd0);
   endtask

   initial begin
      #200000;
      checkOutput("watchdog", 32'd0, 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      rst = 1'b1; req_enq = '0; req_deq = '0; req_data = '0; flush = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK); #1;
      checkResetOutputs("reset");
      rst = 1'b0;
      @(negedge CLK); #1;
      checkOutput("rstwait_pq_rst_n", 32'(pq_rst_n), 32'd0);
      checkOutput("rstwait_ready", 32'(ready), 32'd0);
      @(negedge CLK); #1;
      checkOutput("run_ready", 32'(ready), 32'd1);
      checkOutput("run_pq_rst_n", 32'(pq_rst_n), 32'd1);

      $display("[TB] enqueue then dequeue");
      enqOne(0, 72);
      enqOne(1, 44);
      enqOne(2, 85);
      deqOne(3, 44);
      deqOne(3, 72);
      checkOutput("rsp_latency", 32'(rsp_valid), 32'd1);
      deqOne(3, 85);
      idle();

      $display("[TB] round-robin fairness");
      enqOne(0, 40);
      enqOne(1, 10);
      enqOne(2, 30);
      enqOne(3, 20);
      applyStimulus(4'b0, 4'b1111, 64'b0, 1'b0);
      checkOutput("rr_gnt0", 32'(gnt), 32'b0001); exp_id.push_back(0); exp_data.push_back(10);
      applyStimulus(4'b0, 4'b1110, 64'b0, 1'b0);
      checkOutput("rr_gnt1", 32'(gnt), 32'b0010); exp_id.push_back(1); exp_data.push_back(20);
      applyStimulus(4'b0, 4'b1100, 64'b0, 1'b0);
      checkOutput("rr_gnt2", 32'(gnt), 32'b0100); exp_id.push_back(2); exp_data.push_back(30);
      applyStimulus(4'b0, 4'b1000, 64'b0, 1'b0);
      checkOutput("rr_gnt3", 32'(gnt), 32'b1000); exp_id.push_back(3); exp_data.push_back(40);
      idle();

      $display("[TB] empty stall");
      for (int c = 0; c < 3; c++) begin
         applyStimulus(4'b0, 4'b0010, 64'b0, 1'b0);
         checkOutput("empty_stall_gnt", 32'(gnt), 32'd0);
      end
      applyStimulus(4'b0001, 4'b0010, mkData(0, 7), 1'b0);
      checkOutput("empty_enq_gnt", 32'(gnt), 32'b0001);
      deqOne(1, 7);
      idle();

      $display("[TB] full stall");
      for (int i = 0; i < CAP; i++) enqOne(0, 100 + i);
      for (int c = 0; c < 2; c++) begin
         applyStimulus(4'b0001, 4'b0, mkData(0, 99), 1'b0);
         checkOutput("full_stall_gnt", 32'(gnt), 32'd0);
      end
      applyStimulus(4'b0001, 4'b0100, mkData(0, 99), 1'b0);
      checkOutput("full_deq_gnt", 32'(gnt), 32'b0100);
      exp_id.push_back(2); exp_data.push_back(100);
      applyStimulus(4'b0001, 4'b0, mkData(0, 99), 1'b0);
      checkOutput("full_enq_gnt", 32'(gnt), 32'b0001);
      idle();
      checkOutput("full_count", 32'(pq_count), 32'(CAP));

      $display("[TB] flush");
      doFlush(CAP, 55);
      enqOne(1, 60);
      enqOne(1, 65);
      enqOne(1, 70);
      enqOne(1, 75);
      idle();
      checkOutput("pre_flush_count", 32'(pq_count), 32'd5);
      doFlush(5, 55);
      enqOne(2, 80);
      enqOne(2, 81);
      enqOne(2, 82);
      idle();

      $display("[TB] reset mid-drain");
      applyStimulus(4'b0, 4'b0, 64'b0, 1'b1);
      applyStimulus(4'b0, 4'b0, 64'b0, 1'b0);
      checkOutput("drain1_deq", 32'(pq_deq), 32'd1);
      @(negedge CLK);
      rst = 1'b1;
      @(negedge CLK); #1;
      checkResetOutputs("mid_drain");
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge CLK); #1;
         checkOutput("post_rst_flush_done", 32'(flush_done), 32'd0);
         checkOutput("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      end
      checkOutput("post_rst_ready", 32'(ready), 32'd1);
      checkOutput("post_rst_count", 32'(pq_count), 32'd0);
      enqOne(2, 5);
      deqOne(0, 5);
      idle();
      idle();
      checkOutput("sb_drained", 32'(exp_id.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
